// File: rtl/clk_div_mc_pkg.sv
// Shared constants and helpers for the multi-channel clock divider.
// Define CLK_DIV_MC_SYNC_EN at build time to add the i_sync restart-all input.
package clk_div_mc_pkg;

  localparam int DEF_RATIO_WD = 8;
  localparam int DEF_NUM_CH   = 4;

  typedef enum logic {
    MODE_BYPASS = 1'b0,
    MODE_DIV    = 1'b1
  } mode_e;

  // Length of the high phase: odd ratios get the extra cycle high.
  function automatic int unsigned half_len(input int unsigned r);
    return (r + 1) / 2;
  endfunction

endpackage

// File: rtl/clk_div_mc_ch.sv
// One divider channel: shadow ratio, period counter and registered divided clock.
// Built with CLK_DIV_MC_SYNC_EN, a sync pulse restarts the period from cnt=0.
module clk_div_mc_ch
  import clk_div_mc_pkg::*;
#(
  parameter int RATIO_WD = DEF_RATIO_WD
) (
  input  logic                i_ref_clk,
  input  logic                i_rst,
  input  logic                clk_en,
  input  logic [RATIO_WD-1:0] div_ratio,
`ifdef CLK_DIV_MC_SYNC_EN
  input  logic                sync,
`endif
  output logic                div_clk,
  output logic                tick,
  output logic                active
);

  localparam logic [RATIO_WD-1:0] ONE = RATIO_WD'(1);
  localparam logic [RATIO_WD-1:0] TWO = RATIO_WD'(2);

  mode_e               mode;
  logic [RATIO_WD-1:0] r_act;
  logic [RATIO_WD-1:0] cnt;
  logic [RATIO_WD-1:0] cnt_inc;
  logic [RATIO_WD-1:0] hi_len;
  logic                div_q;
  logic                tick_q;
  logic                at_end;
  logic                restart;
  logic                ratio_ok;
  logic                r_ok;

  assign cnt_inc  = cnt + ONE;
  assign hi_len   = RATIO_WD'(half_len(32'(r_act)));
  assign ratio_ok = div_ratio >= TWO;
  assign r_ok     = r_act >= TWO;
  assign at_end   = cnt == (r_act - ONE);
`ifdef CLK_DIV_MC_SYNC_EN
  assign restart  = at_end | sync;
`else
  assign restart  = at_end;
`endif

  // Shadow ratio only moves at a period boundary so in-flight periods keep their length.
  always_ff @(posedge i_ref_clk or negedge i_rst) begin
    if (!i_rst) begin
      mode   <= MODE_BYPASS;
      r_act  <= '0;
      cnt    <= '0;
      div_q  <= 1'b0;
      tick_q <= 1'b0;
    end else if (!clk_en) begin
      mode   <= MODE_BYPASS;
      r_act  <= div_ratio;
      cnt    <= '0;
      div_q  <= 1'b0;
      tick_q <= 1'b0;
    end else if (mode == MODE_BYPASS) begin
      if (r_ok) begin
        mode   <= MODE_DIV;
        cnt    <= '0;
        div_q  <= 1'b1;
        tick_q <= 1'b1;
      end else begin
        r_act  <= div_ratio;
      end
    end else if (restart) begin
      r_act <= div_ratio;
      cnt   <= '0;
      if (ratio_ok) begin
        div_q  <= 1'b1;
        tick_q <= 1'b1;
      end else begin
        mode   <= MODE_BYPASS;
        div_q  <= 1'b0;
        tick_q <= 1'b0;
      end
    end else begin
      cnt    <= cnt_inc;
      div_q  <= cnt_inc < hi_len;
      tick_q <= 1'b0;
    end
  end

  assign div_clk = (mode == MODE_DIV) ? div_q : i_ref_clk;
  assign tick    = tick_q;
  assign active  = mode == MODE_DIV;

endmodule

// File: rtl/clk_div_mc.sv
// Multi-channel integer clock divider with per-channel enable, ratio and bypass.
// Optional CLK_DIV_MC_SYNC_EN adds i_sync to realign all dividing channels.
module clk_div_mc
  import clk_div_mc_pkg::*;
#(
  parameter int RATIO_WD = DEF_RATIO_WD,
  parameter int NUM_CH   = DEF_NUM_CH
) (
  input  logic                       i_ref_clk,
  input  logic                       i_rst,
  input  logic [NUM_CH-1:0]          i_clk_en,
  input  logic [NUM_CH*RATIO_WD-1:0] i_div_ratio,
`ifdef CLK_DIV_MC_SYNC_EN
  input  logic                       i_sync,
`endif
  output logic [NUM_CH-1:0]          o_div_clk,
  output logic [NUM_CH-1:0]          o_tick,
  output logic [NUM_CH-1:0]          o_active
);

  for (genvar k = 0; k < NUM_CH; k++) begin : g_ch
    clk_div_mc_ch #(
      .RATIO_WD (RATIO_WD)
    ) u_ch (
      .i_ref_clk (i_ref_clk),
      .i_rst     (i_rst),
      .clk_en    (i_clk_en[k]),
      .div_ratio (i_div_ratio[k*RATIO_WD +: RATIO_WD]),
`ifdef CLK_DIV_MC_SYNC_EN
      .sync      (i_sync),
`endif
      .div_clk   (o_div_clk[k]),
      .tick      (o_tick[k]),
      .active    (o_active[k])
    );
  end

endmodule

// File: tb/tb_clk_div_mc.sv
// Directed plus randomized checks of clk_div_mc against a period/phase reference model.
module tb_clk_div_mc;

  localparam int RW = 8;
  localparam int NC = 4;

  logic             i_ref_clk = 1'b0;
  logic             i_rst;
  logic [NC-1:0]    i_clk_en;
  logic [NC*RW-1:0] i_div_ratio;
`ifdef CLK_DIV_MC_SYNC_EN
  logic             i_sync;
`endif
  logic [NC-1:0]    o_div_clk;
  logic [NC-1:0]    o_tick;
  logic [NC-1:0]    o_active;

  int checks   = 0;
  int failures = 0;

  // Reference model: per channel, whether it divides, its period length and position.
  bit m_div [NC];
  int m_per [NC];
  int m_pos [NC];

  clk_div_mc #(.RATIO_WD(RW), .NUM_CH(NC)) dut (
    .i_ref_clk   (i_ref_clk),
    .i_rst       (i_rst),
    .i_clk_en    (i_clk_en),
    .i_div_ratio (i_div_ratio),
`ifdef CLK_DIV_MC_SYNC_EN
    .i_sync      (i_sync),
`endif
    .o_div_clk   (o_div_clk),
    .o_tick      (o_tick),
    .o_active    (o_active)
  );

  always #5 i_ref_clk = ~i_ref_clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      failures++;
      $error("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  function automatic int ratio_of(input int k);
    return int'(i_div_ratio[k*RW +: RW]);
  endfunction

  task automatic set_ratio(input int k, input int v);
    i_div_ratio[k*RW +: RW] = RW'(v);
  endtask

  task automatic model_reset();
    for (int k = 0; k < NC; k++) begin
      m_div[k] = 0; m_per[k] = 0; m_pos[k] = 0;
    end
  endtask

  // Start a new period with the requested ratio, or fall back to bypass if it is 0/1.
  task automatic model_new_period(input int k);
    m_per[k] = ratio_of(k);
    m_pos[k] = 0;
    if (m_per[k] < 2) m_div[k] = 0;
  endtask

  task automatic model_edge();
    bit sy;
    sy = 0;
`ifdef CLK_DIV_MC_SYNC_EN
    sy = i_sync;
`endif
    if (!i_rst) begin
      model_reset();
      return;
    end
    for (int k = 0; k < NC; k++) begin
      if (!i_clk_en[k]) begin
        m_div[k] = 0; m_per[k] = ratio_of(k); m_pos[k] = 0;
      end else if (!m_div[k]) begin
        if (m_per[k] >= 2) begin
          m_div[k] = 1; m_pos[k] = 0;
        end else begin
          m_per[k] = ratio_of(k);
        end
      end else if (sy || m_pos[k] == m_per[k] - 1) begin
        model_new_period(k);
      end else begin
        m_pos[k]++;
      end
    end
  endtask

  task automatic check_outs(input string ph);
    logic exp_clk;
    for (int k = 0; k < NC; k++) begin
      exp_clk = m_div[k] ? logic'(m_pos[k] < (m_per[k] + 1) / 2) : i_ref_clk;
      chk($sformatf("%s_active%0d", ph, k), 32'(o_active[k]), 32'(m_div[k]));
      chk($sformatf("%s_tick%0d", ph, k), 32'(o_tick[k]), 32'(m_div[k] && m_pos[k] == 0));
      chk($sformatf("%s_divclk%0d", ph, k), 32'(o_div_clk[k]), 32'(exp_clk));
    end
  endtask

  task automatic step();
    @(posedge i_ref_clk);
    model_edge();
    #1 check_outs("p");
    @(negedge i_ref_clk);
    check_outs("n");
  endtask

  task automatic next_tick(input int k, output int n);
    n = 0;
    do begin
      step();
      n++;
    end while (o_tick[k] !== 1'b1 && n < 64);
    chk($sformatf("tick_seen%0d", k), 32'(o_tick[k]), 32'd1);
  endtask

  // Count high and low cycles of one whole divided period starting at a tick.
  task automatic measure(input int k, input int ehi, input int elo);
    int n, hi, lo;
    next_tick(k, n);
    hi = 0; lo = 0; n = 0;
    do begin
      if (o_div_clk[k]) hi++; else lo++;
      step();
      n++;
    end while (o_tick[k] !== 1'b1 && n < 64);
    chk($sformatf("hi_len%0d", k), 32'(hi), 32'(ehi));
    chk($sformatf("lo_len%0d", k), 32'(lo), 32'(elo));
  endtask

  initial begin
    int n;
    i_rst = 1'b0;
    i_clk_en = '0;
    i_div_ratio = '0;
`ifdef CLK_DIV_MC_SYNC_EN
    i_sync = 1'b0;
`endif
    model_reset();
    for (int i = 0; i < 3; i++) step();
    chk("rst_active", 32'(o_active), 32'd0);
    chk("rst_tick", 32'(o_tick), 32'd0);

    // Four channels at 2,3,4,7 running side by side.
    set_ratio(0, 2); set_ratio(1, 3); set_ratio(2, 4); set_ratio(3, 7);
    i_clk_en = '1;
    i_rst = 1'b1;
    step();
    chk("post_rst_edge1_active", 32'(o_active), 32'd0);
    step();
    chk("post_rst_edge2_active", 32'(o_active), 32'hF);
    chk("post_rst_edge2_tick", 32'(o_tick), 32'hF);
    for (int i = 0; i < 30; i++) step();
    measure(2, 2, 2);
    measure(0, 1, 1);
    measure(1, 2, 1);
    measure(3, 4, 3);
    set_ratio(1, 5);
    measure(1, 3, 2);

    // Ratio 6 -> 3 requested at cnt=2: the 6-cycle period finishes before 3 takes over.
    set_ratio(3, 6);
    next_tick(3, n);
    step(); step();
    set_ratio(3, 3);
    n = 0;
    do begin step(); n++; end while (o_tick[3] !== 1'b1 && n < 64);
    chk("ratio_change_remaining", 32'(n), 32'd4);
    measure(3, 2, 1);

    // Ratio 0, ratio 1, then enable low: all bypass.
    set_ratio(0, 0);
    step(); step(); step();
    chk("ratio0_active", 32'(o_active[0]), 32'd0);
    set_ratio(0, 1);
    step(); step();
    chk("ratio1_active", 32'(o_active[0]), 32'd0);
    set_ratio(0, 3);
    step(); step(); step();
    chk("ratio3_active", 32'(o_active[0]), 32'd1);
    i_clk_en[0] = 1'b0;
    step();
    chk("en_low_active", 32'(o_active[0]), 32'd0);
    chk("en_low_bypass_n", 32'(o_div_clk[0]), 32'(i_ref_clk));
    i_clk_en[0] = 1'b1;
    set_ratio(0, 2); set_ratio(1, 3); set_ratio(2, 4); set_ratio(3, 7);
    for (int i = 0; i < 20; i++) step();

`ifdef CLK_DIV_MC_SYNC_EN
    i_sync = 1'b1;
    step();
    i_sync = 1'b0;
    chk("sync_tick_all", 32'(o_tick), 32'hF);
    chk("sync_clk_all", 32'(o_div_clk), 32'hF);
    for (int i = 0; i < 10; i++) step();
`endif

    // Asynchronous reset in the middle of a ratio-8 period.
    for (int k = 0; k < NC; k++) set_ratio(k, 8);
    next_tick(0, n);
    next_tick(0, n);
    step(); step(); step();
    #2 i_rst = 1'b0;
    model_reset();
    #1;
    chk("midrst_active", 32'(o_active), 32'd0);
    chk("midrst_tick", 32'(o_tick), 32'd0);
    chk("midrst_divclk", 32'(o_div_clk), 32'(i_ref_clk ? 4'hF : 4'h0));
    @(negedge i_ref_clk);
    step(); step();
    i_rst = 1'b1;
    step(); step();
    chk("rel_tick0", 32'(o_tick[0]), 32'd1);
    n = 0;
    do begin step(); n++; end while (o_tick[0] !== 1'b1 && n < 64);
    chk("rel_first_period", 32'(n), 32'd8);

    // Randomized enables, ratios (including 0 and 1) and sync pulses.
    for (int i = 0; i < 600; i++) begin
      for (int k = 0; k < NC; k++) begin
        if ($urandom_range(0, 15) == 0) i_clk_en[k] = ($urandom_range(0, 3) != 0);
        if ($urandom_range(0, 11) == 0) set_ratio(k, $urandom_range(0, 9));
      end
`ifdef CLK_DIV_MC_SYNC_EN
      i_sync = ($urandom_range(0, 29) == 0);
`endif
      step();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/clk_div_mc.md
CLK_DIV_MC -- requirements
Module: clk_div_mc

Interface
REQ-001 Parameter RATIO_WD, default 8, width of each channel's division ratio.
REQ-002 Parameter NUM_CH, default 4, number of independent divider channels.
REQ-003 i_ref_clk  input  1  reference clock; all logic on its rising edge.
REQ-004 i_rst  input  1  reset, asynchronous, active-low.
REQ-005 i_clk_en  input  NUM_CH  per-channel divider enable.
REQ-006 i_div_ratio  input  NUM_CH*RATIO_WD  per-channel requested ratio; channel k occupies bits [k*RATIO_WD +: RATIO_WD].
REQ-007 i_sync  input  1  restart-all pulse; present only with CLK_DIV_MC_SYNC_EN.
REQ-008 o_div_clk  output  NUM_CH  per-channel divided clock, or i_ref_clk in bypass.
REQ-009 o_tick  output  NUM_CH  per-channel one-cycle pulse at the start of each divided period.
REQ-010 o_active  output  NUM_CH  per-channel flag: 1 = dividing, 0 = bypass.

Function
REQ-011 Each channel holds a shadow ratio R_act, a period counter cnt (RATIO_WD bits) and a registered div_q.
REQ-012 Channel dividing when i_clk_en[k]=1 and R_act>=2; otherwise bypass.
REQ-013 Bypass: o_div_clk[k]=i_ref_clk combinationally; cnt=0, div_q=0, o_tick[k]=0, o_active[k]=0.
REQ-014 Dividing: cnt counts 0..R_act-1, then wraps to 0; period is exactly R_act ref cycles.
REQ-015 div_q=1 while cnt < ceil(R_act/2), else 0; odd ratios give high phase one ref cycle longer than low phase.
REQ-016 o_div_clk[k]=div_q when dividing; output driven from a flop, with no combinational path from cnt.
REQ-017 o_tick[k]=1 for exactly one ref cycle when cnt==0 while dividing.
REQ-018 R_act loads i_div_ratio[k] only at a period boundary (cnt==R_act-1 while dividing), or every cycle while in bypass, so a ratio change never truncates or stretches an in-flight period.
REQ-019 i_clk_en[k] 0->1 with R_act>=2: next edge cnt=0, div_q=1, o_tick=1; the first divided period is full length.
REQ-020 i_clk_en[k] 1->0: bypass takes effect at the next edge; cnt and div_q clear.
REQ-021 Requested ratio 0 or 1 loaded at a boundary: channel enters bypass at that edge.
REQ-022 Channels are fully independent; one channel's state never affects another's.

Reset
REQ-023 While i_rst=0: all cnt=0, div_q=0, R_act=0, o_tick=0, o_active=0; o_div_clk=i_ref_clk (bypass).
REQ-024 Reset release mid-operation: dividing starts from cnt=0 per REQ-019 once R_act is loaded, i.e. two edges after release.

Configuration
REQ-025 Macro CLK_DIV_MC_SYNC_EN defined: i_sync exists; when i_sync=1 every dividing channel loads R_act from i_div_ratio, sets cnt=0 and div_q=1 on the same edge, aligning rising edges; i_sync takes priority over the REQ-018 boundary rule.
REQ-026 Macro undefined: i_sync port and its logic are absent; behaviour otherwise identical.

Structure
REQ-027 Package clk_div_mc_pkg holds the default RATIO_WD and NUM_CH constants and a function for the ceil(R/2) high-phase length.
REQ-028 Single-channel sub-module clk_div_mc_ch, instantiated NUM_CH times by generate; the top contains only slicing and instantiation.

Verification
REQ-029 Ratio 4, enabled: o_div_clk period 4 ref cycles, high 2/low 2; o_tick every 4th cycle.
REQ-030 Ratio 5: high 3, low 2 ref cycles; ratio 2: high 1, low 1.
REQ-031 Ratio changed 6->3 at cnt=2: current period completes at 6 cycles, then 3-cycle periods; no runt pulse.
REQ-032 Ratio 0, then ratio 1, then enable low: o_div_clk equals i_ref_clk and o_active=0 in each case.
REQ-033 Channels 0..3 at ratios 2,3,4,7 run concurrently with no interaction; with CLK_DIV_MC_SYNC_EN, one i_sync pulse gives all four rising edges on the same ref edge.
REQ-034 Reset asserted mid-period at ratio 8: outputs clear immediately; after release the first period is a full 8 cycles.
